// File: rtl/t_pulse_gen.sv
// -----------------------------------------------------------------------------
// t_pulse_gen
//
// Command stage in front of a T flip-flop. A raw, bouncy push-button level is
// synchronised, debounced in both directions, and turned into a one-cycle
// toggle pulse per accepted press. While the button stays held, auto-repeat
// pulses can optionally follow. Every pulse also bumps a wrapping press counter
// that is there for debug visibility.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   btn_in     in   1      raw asynchronous button level (1 = pressed)
//   repeat_en  in   1      synchronous auto-repeat enable
//   t          out  1      registered toggle pulse, one cycle per press/repeat
//   pressed    out  1      registered debounced button level
//   press_cnt  out  CNT_W  number of t pulses, wraps modulo 2**CNT_W
//
// States
//   IDLE   | button released and debounced; waiting for a high sample
//   ARM    | counting consecutive high samples toward press acceptance
//   HELD   | press accepted; timing the hold before the first repeat
//   REPEAT | auto-repeat active; one pulse every REPEAT_CYCLES
//   REL    | counting consecutive low samples toward release acceptance
// -----------------------------------------------------------------------------
module t_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             repeat_en,
    output logic             t,
    output logic             pressed,
    output logic [CNT_W-1:0] press_cnt
);

    // Each counter only has to reach its parameter minus one.
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int REP_W  = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        HELD   = 3'd2,
        REPEAT = 3'd3,
        REL    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q;
    logic               btn_s_q;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               t_q, t_d;
    logic               pressed_q, pressed_d;
    logic [CNT_W-1:0]   press_cnt_q, press_cnt_d;

    // Two-flop synchroniser; btn_in is asynchronous to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            btn_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            t_q         <= 1'b0;
            pressed_q   <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            t_q         <= t_d;
            pressed_q   <= pressed_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        t_d         = 1'b0;
        pressed_d   = pressed_q;
        press_cnt_d = press_cnt_q;

        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    // A single-sample debounce accepts the press immediately.
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = HELD;
                        t_d        = 1'b1;
                        pressed_d  = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        state_d  = ARM;
                        db_cnt_d = DB_W'(1);
                    end
                end
            end

            ARM: begin
                if (!btn_s_q) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = HELD;
                    t_d        = 1'b1;
                    pressed_d  = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            HELD: begin
                if (!btn_s_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = IDLE;
                        pressed_d = 1'b0;
                        db_cnt_d  = '0;
                    end else begin
                        state_d  = REL;
                        db_cnt_d = DB_W'(1);
                    end
                end else if (repeat_en && (hold_cnt_q == HOLD_LAST)) begin
                    state_d   = REPEAT;
                    t_d       = 1'b1;
                    rep_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    // Saturates so a later repeat_en starts repeating at once.
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            REPEAT: begin
                if (!btn_s_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = IDLE;
                        pressed_d = 1'b0;
                        db_cnt_d  = '0;
                    end else begin
                        state_d  = REL;
                        db_cnt_d = DB_W'(1);
                    end
                end else if (!repeat_en) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    t_d       = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end

            REL: begin
                // A high sample here is release bounce, not a new press.
                if (btn_s_q) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    pressed_d = 1'b0;
                    db_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (t_d) begin
            press_cnt_d = press_cnt_q + CNT_W'(1);
        end
    end

    assign t         = t_q;
    assign pressed   = pressed_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_t_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_t_pulse_gen
//
// Drives three t_pulse_gen instances from shared inputs:
//   a : default parameters
//   b : default timing, 2-bit press counter (wrap behaviour)
//   c : DEBOUNCE_CYCLES=1, HOLD_CYCLES=3, REPEAT_CYCLES=2, 4-bit counter
// Every cycle all outputs are compared against a behavioural model that works
// on the delayed sample stream in terms of streak lengths and elapsed times.
// Directed checks add the absolute timing points for the default instance.
// -----------------------------------------------------------------------------
module tb_t_pulse_gen;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       repeat_en;

    logic       t_a, pressed_a;
    logic [7:0] pcnt_a;
    logic       t_b, pressed_b;
    logic [1:0] pcnt_b;
    logic       t_c, pressed_c;
    logic [3:0] pcnt_c;

    int n_vec = 0;
    int n_err = 0;

    t_pulse_gen #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16), .REPEAT_CYCLES(8), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
        .t(t_a), .pressed(pressed_a), .press_cnt(pcnt_a)
    );

    t_pulse_gen #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16), .REPEAT_CYCLES(8), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
        .t(t_b), .pressed(pressed_b), .press_cnt(pcnt_b)
    );

    t_pulse_gen #(
        .DEBOUNCE_CYCLES(1), .HOLD_CYCLES(3), .REPEAT_CYCLES(2), .CNT_W(4)
    ) dut_c (
        .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
        .t(t_c), .pressed(pressed_c), .press_cnt(pcnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: s1/s2 are the two sample delays, streak counts
    // consecutive highs while released, rel counts consecutive lows while
    // pressed, age is time held since acceptance, rep_age time since last repeat.
    typedef struct {
        bit s1;
        bit s2;
        bit pressed;
        bit t;
        int streak;
        int rel;
        int age;
        bit rep;
        int rep_age;
        int cnt;
    } mdl_t;

    mdl_t ma, mb, mc;

    task automatic mreset(output mdl_t m);
        m = '{default: 0};
    endtask

    task automatic mstep(inout mdl_t m, input bit b, input bit re,
                         input int db, input int hold, input int rpt, input int cw);
        bit s;
        s    = m.s2;
        m.s2 = m.s1;
        m.s1 = b;
        m.t  = 1'b0;
        if (!m.pressed) begin
            if (s) begin
                m.streak = m.streak + 1;
                if (m.streak >= db) begin
                    m.pressed = 1'b1;
                    m.t       = 1'b1;
                    m.rel     = 0;
                    m.age     = 0;
                    m.rep     = 1'b0;
                end
            end else begin
                m.streak = 0;
            end
        end else if (!s) begin
            m.rel = m.rel + 1;
            if (m.rel >= db) begin
                m.pressed = 1'b0;
                m.streak  = 0;
                m.rel     = 0;
            end
        end else if (m.rel > 0) begin
            m.rel = 0;
            m.age = 0;
            m.rep = 1'b0;
        end else if (!m.rep) begin
            if (re && m.age == hold - 1) begin
                m.t       = 1'b1;
                m.rep     = 1'b1;
                m.rep_age = 0;
            end else if (m.age < hold - 1) begin
                m.age = m.age + 1;
            end
        end else begin
            if (!re) begin
                m.rep = 1'b0;
                m.age = 0;
            end else if (m.rep_age == rpt - 1) begin
                m.t       = 1'b1;
                m.rep_age = 0;
            end else begin
                m.rep_age = m.rep_age + 1;
            end
        end
        if (m.t) m.cnt = (m.cnt + 1) % (1 << cw);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a.t",         32'(t_a),       32'(ma.t));
        chk("a.pressed",   32'(pressed_a), 32'(ma.pressed));
        chk("a.press_cnt", 32'(pcnt_a),    32'(ma.cnt));
        chk("b.t",         32'(t_b),       32'(mb.t));
        chk("b.pressed",   32'(pressed_b), 32'(mb.pressed));
        chk("b.press_cnt", 32'(pcnt_b),    32'(mb.cnt));
        chk("c.t",         32'(t_c),       32'(mc.t));
        chk("c.pressed",   32'(pressed_c), 32'(mc.pressed));
        chk("c.press_cnt", 32'(pcnt_c),    32'(mc.cnt));
    endtask

    // One active edge: inputs present at the edge feed the model, outputs
    // are compared 1 ns later.
    task automatic tick();
        bit b, r;
        b = btn_in;
        r = repeat_en;
        @(posedge clk);
        mstep(ma, b, r, 4, 16, 8, 8);
        mstep(mb, b, r, 4, 16, 8, 2);
        mstep(mc, b, r, 1, 3, 2, 4);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic async_reset();
        rst = 1'b0;
        #2;
        mreset(ma);
        mreset(mb);
        mreset(mc);
        check_all();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int first_t;
        int n_t;
        int fall;
        int prev_p;
        int cnt0;
        int run;
        int pt[$];
        int exp_rep[6];

        exp_rep = '{6, 22, 30, 38, 46, 54};

        rst       = 1'b0;
        btn_in    = 1'b0;
        repeat_en = 1'b0;
        mreset(ma);
        mreset(mb);
        mreset(mc);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2;
        rst = 1'b1;
        repeat (3) tick();

        // Single press, no repeat: pulse on tick 6, release seen on tick 36.
        first_t = 0; n_t = 0; fall = 0; prev_p = 0;
        for (int i = 1; i <= 40; i++) begin
            btn_in = (i <= 30);
            tick();
            if (t_a === 1'b1) begin
                n_t = n_t + 1;
                if (first_t == 0) first_t = i;
            end
            if (prev_p == 1 && pressed_a === 1'b0) fall = i;
            prev_p = (pressed_a === 1'b1) ? 1 : 0;
            if (i == 30) chk("press_cnt_after_press", 32'(pcnt_a), 32'd1);
        end
        chk("press_latency", 32'(first_t), 32'd6);
        chk("single_pulse_count", 32'(n_t), 32'd1);
        chk("release_latency", 32'(fall), 32'd36);

        // Three high samples only: must be rejected.
        n_t = 0;
        for (int i = 1; i <= 12; i++) begin
            btn_in = (i <= 3);
            tick();
            if (t_a === 1'b1) n_t = n_t + 1;
            chk("bounce_pressed", 32'(pressed_a), 32'd0);
        end
        chk("bounce_no_pulse", 32'(n_t), 32'd0);
        chk("bounce_cnt", 32'(pcnt_a), 32'd1);

        // Auto-repeat: held E0..E57.
        repeat_en = 1'b1;
        cnt0 = 1;
        pt.delete();
        fall = 0; prev_p = 0;
        for (int i = 1; i <= 68; i++) begin
            btn_in = (i <= 58);
            tick();
            if (t_a === 1'b1) pt.push_back(i);
            if (prev_p == 1 && pressed_a === 1'b0) fall = i;
            prev_p = (pressed_a === 1'b1) ? 1 : 0;
        end
        chk("repeat_pulse_count", 32'(pt.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk("repeat_pulse_time", 32'((k < pt.size()) ? pt[k] : -1), 32'(exp_rep[k]));
        end
        chk("repeat_cnt", 32'(pcnt_a), 32'(cnt0 + 6));
        chk("repeat_release", 32'(fall), 32'd64);

        // Release bounce: accepted press, two low samples, then high again.
        repeat_en = 1'b0;
        btn_in = 1'b1;
        repeat (10) tick();
        cnt0 = pcnt_a;
        n_t = 0;
        for (int i = 1; i <= 14; i++) begin
            btn_in = !(i <= 2);
            tick();
            if (t_a === 1'b1) n_t = n_t + 1;
            chk("relbounce_pressed", 32'(pressed_a), 32'd1);
        end
        chk("relbounce_no_pulse", 32'(n_t), 32'd0);
        chk("relbounce_cnt", 32'(pcnt_a), 32'(cnt0));
        btn_in = 1'b0;
        repeat (8) tick();

        // Asynchronous reset while repeating, button still held afterwards.
        repeat_en = 1'b1;
        btn_in = 1'b1;
        repeat (30) tick();
        async_reset();
        chk("rst_t", 32'(t_a), 32'd0);
        chk("rst_pressed", 32'(pressed_a), 32'd0);
        chk("rst_cnt", 32'(pcnt_a), 32'd0);
        first_t = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (t_a === 1'b1 && first_t == 0) first_t = i;
        end
        chk("rst_repress_latency", 32'(first_t), 32'd6);
        chk("rst_repress_cnt", 32'(pcnt_a), 32'd1);
        btn_in = 1'b0;
        repeat_en = 1'b0;
        repeat (8) tick();

        // Counter wrap on the 2-bit instance.
        async_reset();
        for (int p = 1; p <= 5; p++) begin
            btn_in = 1'b1;
            repeat (8) tick();
            btn_in = 1'b0;
            repeat (8) tick();
            chk("wrap_cnt", 32'(pcnt_b), 32'(p % 4));
        end

        // Randomised run-length stimulus with occasional enable flips and resets.
        run = 0;
        for (int i = 0; i < 800; i++) begin
            if (run == 0) begin
                btn_in = 1'($urandom_range(0, 1));
                run    = int'($urandom_range(1, 9));
                if ($urandom_range(0, 5) == 0) run = run + 25;
            end
            run = run - 1;
            if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
            if ($urandom_range(0, 249) == 0) async_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
